// File: rtl/alu_exec_unit.sv
// Execution unit driven by the 3-bit ALU control code: single-cycle ALU ops plus an
// iterative shift-add multiplier, with a valid/ready handshake on both sides.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [SHW:0] MUL_STEPS = WIDTH[SHW:0];

  logic [1:0]       state_r, state_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic             zero_r, zero_s;
  logic             out_valid_r, out_valid_s;
  logic             in_ready_r, in_ready_s;
  logic [WIDTH-1:0] mcand_r, mcand_s;
  logic [WIDTH-1:0] mplier_r, mplier_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic [SHW:0]     cnt_r, cnt_s;

  // MUL is never routed here; it falls into the default with a defined value.
  function automatic logic [WIDTH-1:0] simple_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLL:  r = x << y[SHW-1:0];
      OP_SRL:  r = x >> y[SHW-1:0];
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_s  = state_r;
    result_s = result_r;
    mcand_s  = mcand_r;
    mplier_s = mplier_r;
    acc_s    = acc_r;
    cnt_s    = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) begin
          if (alu_control == OP_MUL) begin
            state_s  = ST_MUL;
            mcand_s  = a;
            mplier_s = b;
            acc_s    = {WIDTH{1'b0}};
            cnt_s    = {(SHW+1){1'b0}};
          end else begin
            state_s  = ST_DONE;
            result_s = simple_op(alu_control, a, b);
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        // WIDTH shift-add steps, then one extra cycle to publish the accumulator.
        if (cnt_r < MUL_STEPS) begin
          if (mplier_r[0]) begin
            acc_s = acc_r + mcand_r;
          end else begin
            acc_s = acc_r;
          end
          mcand_s  = mcand_r << 1;
          mplier_s = mplier_r >> 1;
          cnt_s    = cnt_r + {{SHW{1'b0}}, 1'b1};
        end else begin
          result_s = acc_r;
          state_s  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    zero_s      = (result_s == {WIDTH{1'b0}});
    out_valid_s = (state_s == ST_DONE);
    in_ready_s  = (state_s == ST_IDLE);
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b1;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      mcand_r     <= {WIDTH{1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      cnt_r       <= {(SHW+1){1'b0}};
    end else begin
      state_r     <= state_s;
      result_r    <= result_s;
      zero_r      <= zero_s;
      out_valid_r <= out_valid_s;
      in_ready_r  <= in_ready_s;
      mcand_r     <= mcand_s;
      mplier_r    <= mplier_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 3-bit ALU control code generated by the ALU control decoder.
- Accepts one operation per valid/ready handshake and returns a registered result with a zero flag.
- Simple ops complete in one cycle; multiply runs as an iterative shift-add sequence.
- Sits between the register-file read stage and writeback/branch-compare logic.

Parameters:
WIDTH, 32, operand/result width in bits (power of two, >= 8)
SHW, $clog2(WIDTH), shift-amount bits taken from b

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept an operation this cycle
alu_control  input  3  operation code, sampled at accept
a  input  WIDTH  operand A, sampled at accept
b  input  WIDTH  operand B, sampled at accept
out_valid  output  1  result valid, held until consumed
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
zero  output  1  high when result == 0

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Op codes:
  - 000 ADD: a+b, mod 2^WIDTH, no overflow flag.
  - 001 SUB: a-b, mod 2^WIDTH.
  - 010 AND.
  - 011 OR.
  - 100 SLT: signed a<b gives 1, else 0, zero-extended.
  - 101 SLL: a << b[SHW-1:0].
  - 110 SRL: logical a >> b[SHW-1:0].
  - 111 MUL: low WIDTH bits of unsigned a*b.
- Reset (rst_n low, any time, mid-operation included): state=IDLE, in_ready=0 while rst_n low, out_valid=0, result=0, zero=1, multiply registers cleared. An in-flight op is discarded. in_ready rises in the first cycle after rst_n deasserts.
- States:
  - IDLE: in_ready=1. Accept when in_valid && in_ready at a rising edge. Ops 000–110 go to DONE with the result registered at that same edge. Op 111 goes to MUL, with a/b latched and accumulator and counter cleared.
  - MUL: in_ready=0. Each cycle: if multiplier bit0 is set, accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++. Exit after exactly WIDTH iterations: result registered and state goes to DONE.
  - DONE: out_valid=1, in_ready=0. result and zero stay stable until out_ready is sampled high, then return to IDLE with out_valid=0 next cycle.
- Latency:
  - Single-cycle op accepted at edge t: out_valid high from t through the edge where out_ready=1. Minimum one-cycle pulse if out_ready is held 1.
  - MUL: out_valid rises WIDTH+1 edges after accept.
- Throughput: no overlap. in_ready and out_valid are never both high. Max one simple op per 2 cycles.
- in_valid while in_ready=0: ignored. Requester must hold request and operands stable until accepted.
- Operand/code changes after accept have no effect.
- zero is derived from the registered result. It is a register output, not combinational from inputs.
- No X propagation: all unused codes are defined above. Shift amounts >= WIDTH are impossible because only SHW bits are used.

Test Plan:
- Reset, then a=7, b=5, code 000, in_valid pulse, out_ready=1 -> result=12, zero=0, out_valid high exactly 1 cycle, in_ready back 1 cycle after.
- SUB a=9, b=9 -> result=0, zero=1. SLT a=0xFFFFFFFF, b=1 -> result=1. SLT a=1, b=0xFFFFFFFF -> 0.
- SLL a=1, b=31 -> 0x80000000. SRL a=0x80000000, b=0x24 (shift 4) -> 0x08000000. AND/OR with 0xF0F0F0F0/0x0FF00FF0 -> 0x00F000F0 / 0xFFF0FFF0.
- MUL a=0x10001, b=0x10001 -> result=0x00020001, out_valid asserted exactly 33 edges after accept. in_ready=0 throughout; a second in_valid during MUL is not accepted.
- Backpressure: ADD 3+4 with out_ready=0 for 5 cycles -> result=7 held stable, out_valid held, in_ready=0. Release out_ready -> handshake completes.
- Async reset asserted mid-MUL (cycle 10) between clock edges -> out_valid=0, result=0, zero=1 immediately. After release, a fresh ADD 1+1 -> 2 with normal latency.
